// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, stage-register indices and default parameters.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        HALT    = 2'd2
    } pipe_state_e;

    // Bit positions of the stage registers inside the en/clr vectors.
    localparam int unsigned STG_IF_ID  = 0;
    localparam int unsigned STG_ID_EX  = 1;
    localparam int unsigned STG_EX_MEM = 2;
    localparam int unsigned STG_MEM_WB = 3;
    localparam int unsigned NUM_STG    = 4;

    localparam int unsigned DEF_MD_LAT = 4;
    localparam int unsigned DEF_CNT_W  = 32;

    // Width needed to hold lat-1 (the first MD_BUSY count), never below 1 bit.
    function automatic int unsigned md_cnt_width(input int unsigned lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard requests from the pipeline and the stage enable/clear controls back to it.
// master: the hazard controller; slave: the pipeline datapath.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);

    logic             load_use_hz;
    logic             branch_taken;
    logic             md_start;
    logic             syscall_wb;
    logic             resume;

    logic             pc_en;
    logic             if_id_en;
    logic             if_id_clr;
    logic             id_ex_en;
    logic             id_ex_clr;
    logic             ex_mem_en;
    logic             ex_mem_clr;
    logic             mem_wb_en;
    logic             mem_wb_clr;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        input  load_use_hz, branch_taken, md_start, syscall_wb, resume,
        output pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr,
               ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr,
               halted, stall_cycles, flush_count
    );

    modport slave (
        output load_use_hz, branch_taken, md_start, syscall_wb, resume,
        input  pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr,
               ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr,
               halted, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (load-use, branch, mult/div, SYSCALL).
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_LAT = DEF_MD_LAT,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_hazard_ctrl_if.master  bus
);

    localparam int unsigned MD_CNT_W = md_cnt_width(MD_LAT);

    pipe_state_e         state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                md_done_q, md_done_d;

    logic [NUM_STG-1:0]  en;
    logic [NUM_STG-1:0]  clr;
    logic                pc_en;
    logic                halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            md_cnt_q  <= '0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            md_done_q <= md_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        md_done_d = md_done_q;
        unique case (state_q)
            RUN: begin
                if (bus.syscall_wb) begin
                    state_d = HALT;
                end else if (bus.md_start && !md_done_q) begin
                    if (MD_LAT > 1) begin
                        md_cnt_d = MD_CNT_W'(MD_LAT - 1);
                        state_d  = MD_BUSY;
                    end else begin
                        md_done_d = 1'b1;
                    end
                end
                // Once EX advances, the finished mult/div has left and the mask must drop.
                if (en[STG_EX_MEM]) begin
                    md_done_d = 1'b0;
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - MD_CNT_W'(1);
                if (md_cnt_q == MD_CNT_W'(1)) begin
                    md_done_d = 1'b1;
                    state_d   = RUN;
                end
            end
            HALT: begin
                if (bus.resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        en     = '0;
        clr    = '0;
        pc_en  = 1'b0;
        halted = 1'b0;
        if (!rst_n) begin
            clr = '1;
        end else begin
            unique case (state_q)
                RUN: begin
                    en    = '1;
                    pc_en = 1'b1;
                    if (bus.syscall_wb) begin
                        en    = '0;
                        pc_en = 1'b0;
                    end else if (bus.md_start && !md_done_q) begin
                        pc_en           = 1'b0;
                        en[STG_IF_ID]   = 1'b0;
                        en[STG_ID_EX]   = 1'b0;
                        en[STG_EX_MEM]  = 1'b0;
                        clr[STG_MEM_WB] = 1'b1;
                    end else if (bus.branch_taken) begin
                        clr[STG_IF_ID] = 1'b1;
                        clr[STG_ID_EX] = 1'b1;
                    end else if (bus.load_use_hz) begin
                        pc_en          = 1'b0;
                        en[STG_IF_ID]  = 1'b0;
                        clr[STG_ID_EX] = 1'b1;
                    end
                end
                MD_BUSY: begin
                    en[STG_MEM_WB]  = 1'b1;
                    clr[STG_MEM_WB] = 1'b1;
                end
                HALT: begin
                    halted = 1'b1;
                    // Retire the SYSCALL as a bubble so it cannot halt us again.
                    if (bus.resume) begin
                        en[STG_MEM_WB]  = 1'b1;
                        clr[STG_MEM_WB] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_en      = pc_en;
    assign bus.if_id_en   = en[STG_IF_ID];
    assign bus.id_ex_en   = en[STG_ID_EX];
    assign bus.ex_mem_en  = en[STG_EX_MEM];
    assign bus.mem_wb_en  = en[STG_MEM_WB];
    assign bus.if_id_clr  = clr[STG_IF_ID];
    assign bus.id_ex_clr  = clr[STG_ID_EX];
    assign bus.ex_mem_clr = clr[STG_EX_MEM];
    assign bus.mem_wb_clr = clr[STG_MEM_WB];
    assign bus.halted     = halted;

`ifdef PIPE_PERF_CNT_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = rst_n && !pc_en && (state_q != HALT);
    // In RUN only the taken-branch case clears IF/ID.
    assign flush_inc = rst_n && (state_q == RUN) && clr[STG_IF_ID];

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (bus.stall_cycles)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (bus.flush_count)
    );
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_count  = {CNT_W{1'b0}};
`endif

endmodule
